// File: rtl/dcache_wt_if.sv
// CPU-side and memory-side signal bundle of the write-through data cache.
// slave  : the cache view (takes CPU requests and memory responses).
// master : the environment view (CPU pipeline plus data memory).
// Signals: req_i/we_i/byte_op_i/addr_i/wd_i (CPU request), rd_o/stall_o (CPU
// response), mem_req_o/mem_we_o/mem_byte_op_o/mem_addr_o/mem_wd_o (memory
// request), mem_rd_i/mem_ready_i (memory response).
interface dcache_wt_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_i;
    logic                  we_i;
    logic                  byte_op_i;
    logic [DATA_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wd_i;
    logic [DATA_WIDTH-1:0] rd_o;
    logic                  stall_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic                  mem_byte_op_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wd_o;
    logic [DATA_WIDTH-1:0] mem_rd_i;
    logic                  mem_ready_i;

    modport slave (
        input  req_i, we_i, byte_op_i, addr_i, wd_i, mem_rd_i, mem_ready_i,
        output rd_o, stall_o, mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o
    );

    modport master (
        output req_i, we_i, byte_op_i, addr_i, wd_i, mem_rd_i, mem_ready_i,
        input  rd_o, stall_o, mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o
    );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Ports: clk_i (clock), rst_i (synchronous active-high reset), bus (dcache_wt_if
// slave: CPU request/response and data-memory request/response).
// Load hits answer combinationally in IDLE; load misses refill one word; every
// store is written through to memory and updates the line only on a hit.
module dcache_wt #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned SETS       = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    dcache_wt_if.slave bus
);
    localparam int unsigned BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = DATA_WIDTH - IDX_W - OFF_W;

    typedef enum logic [1:0] {ST_IDLE, ST_REFILL, ST_WRITE} state_e;

    // Line storage
    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS];

    // FSM and latched request
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic                  byte_op_q, byte_op_d;
    logic                  hit_q, hit_d;

    // Live address fields
    logic [OFF_W-1:0]      off_in;
    logic [IDX_W-1:0]      idx_in;
    logic [TAG_W-1:0]      tag_in;
    logic [DATA_WIDTH-1:0] line_c;
    logic                  hit_c;
    logic [BYTE_WIDTH-1:0] byte_c;

    // Latched address fields
    logic [OFF_W-1:0]      off_l;
    logic [IDX_W-1:0]      idx_l;
    logic [TAG_W-1:0]      tag_l;
    logic [DATA_WIDTH-1:0] aligned_l;
    logic [DATA_WIDTH-1:0] merged_c;

    // Line update strobes
    logic                  fill_c;
    logic                  upd_c;

    // Output drivers
    logic [DATA_WIDTH-1:0] rd_c;
    logic                  stall_c;
    logic                  mem_req_c;
    logic                  mem_we_c;
    logic                  mem_byte_op_c;
    logic [DATA_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wd_c;

    assign off_in    = bus.addr_i[OFF_W-1:0];
    assign idx_in    = bus.addr_i[OFF_W +: IDX_W];
    assign tag_in    = bus.addr_i[DATA_WIDTH-1 -: TAG_W];
    assign line_c    = data_q[idx_in];
    assign hit_c     = bus.req_i & valid_q[idx_in] & (tag_q[idx_in] == tag_in);

    assign off_l     = addr_q[OFF_W-1:0];
    assign idx_l     = addr_q[OFF_W +: IDX_W];
    assign tag_l     = addr_q[DATA_WIDTH-1 -: TAG_W];
    assign aligned_l = {addr_q[DATA_WIDTH-1:OFF_W], OFF_W'(0)};

    // Byte lane selected by the live offset for LBU
    always_comb begin
        byte_c = '0;
        for (int b = 0; b < int'(BYTES); b++) begin
            if (off_in == OFF_W'(b)) byte_c = line_c[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Line contents after a store hit: whole word, or just the addressed lane
    always_comb begin
        merged_c = data_q[idx_l];
        if (byte_op_q) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (off_l == OFF_W'(b)) merged_c[b*BYTE_WIDTH +: BYTE_WIDTH] = wd_q[BYTE_WIDTH-1:0];
            end
        end else begin
            merged_c = wd_q;
        end
    end

    // Next state, latched request and CPU/memory outputs
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wd_d          = wd_q;
        byte_op_d     = byte_op_q;
        hit_d         = hit_q;
        rd_c          = '0;
        stall_c       = 1'b0;
        mem_req_c     = 1'b0;
        mem_we_c      = 1'b0;
        mem_byte_op_c = 1'b0;
        mem_addr_c    = '0;
        mem_wd_c      = '0;
        fill_c        = 1'b0;
        upd_c         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_i) begin
                    if (bus.we_i) begin
                        stall_c   = 1'b1;
                        addr_d    = bus.addr_i;
                        wd_d      = bus.wd_i;
                        byte_op_d = bus.byte_op_i;
                        hit_d     = hit_c;
                        state_d   = ST_WRITE;
                    end else if (hit_c) begin
                        rd_c = bus.byte_op_i ? DATA_WIDTH'(byte_c) : line_c;
                    end else begin
                        stall_c = 1'b1;
                        addr_d  = {bus.addr_i[DATA_WIDTH-1:OFF_W], OFF_W'(0)};
                        state_d = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                stall_c    = 1'b1;
                mem_req_c  = 1'b1;
                mem_addr_c = aligned_l;
                if (bus.mem_ready_i) begin
                    fill_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // The CPU is released in the cycle memory accepts the write
                stall_c       = ~bus.mem_ready_i;
                mem_req_c     = 1'b1;
                mem_we_c      = 1'b1;
                mem_byte_op_c = byte_op_q;
                mem_addr_c    = addr_q;
                mem_wd_c      = wd_q;
                if (bus.mem_ready_i) begin
                    upd_c   = hit_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and latched request registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wd_q      <= '0;
            byte_op_q <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            byte_op_q <= byte_op_d;
            hit_q     <= hit_d;
        end
    end

    // Valid bits; a reset in the same cycle as a refill wins
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (fill_c) begin
            valid_q[idx_l] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; they are qualified by valid_q
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (fill_c) begin
                tag_q[idx_l]  <= tag_l;
                data_q[idx_l] <= bus.mem_rd_i;
            end else if (upd_c) begin
                data_q[idx_l] <= merged_c;
            end
        end
    end

    assign bus.rd_o          = rd_c;
    assign bus.stall_o       = stall_c;
    assign bus.mem_req_o     = mem_req_c;
    assign bus.mem_we_o      = mem_we_c;
    assign bus.mem_byte_op_o = mem_byte_op_c;
    assign bus.mem_addr_o    = mem_addr_c;
    assign bus.mem_wd_o      = mem_wd_c;
endmodule
